// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
//   Bundles the EX/MEM-side inputs and the MEM/WB, branch and debug outputs of
//   the MEM pipeline stage.
//   modport master : driver of the stage (EX/MEM latch, debug unit, bench)
//   modport slave  : the mem_stage itself
// Signals
//   i_step                 pipeline advance enable
//   i_alu_result           effective address / ALU result
//   i_write_data           store data (rt)
//   i_mem_read/_write      load / store access
//   i_reg_write            writeback enable
//   i_mem_to_reg           select loaded value for writeback
//   i_word_size            [1:0] 00 byte, 01 half, 10 word; [2] zero-extend
//   i_branch, i_cero       branch decision inputs
//   i_branch_addr          branch target
//   i_rd_addr              destination register
//   i_debug_addr           debug word index
//   o_pc_src               taken branch (combinational)
//   o_branch_addr          branch target passthrough (combinational)
//   o_wb_data              registered writeback data
//   o_wb_rd_addr           registered destination register
//   o_wb_reg_write         registered writeback enable
//   o_misaligned           registered misaligned flag
//   o_debug_data           debug read data
// -----------------------------------------------------------------------------
interface mem_stage_if #(
  parameter int unsigned NB      = 32,
  parameter int unsigned NB_ADDR = 8,
  parameter int unsigned NB_REG  = 5
);

  logic                i_step;
  logic [NB-1:0]       i_alu_result;
  logic [NB-1:0]       i_write_data;
  logic                i_mem_read;
  logic                i_mem_write;
  logic                i_reg_write;
  logic                i_mem_to_reg;
  logic [2:0]          i_word_size;
  logic                i_branch;
  logic                i_cero;
  logic [NB-1:0]       i_branch_addr;
  logic [NB_REG-1:0]   i_rd_addr;
  logic [NB_ADDR-1:0]  i_debug_addr;

  logic                o_pc_src;
  logic [NB-1:0]       o_branch_addr;
  logic [NB-1:0]       o_wb_data;
  logic [NB_REG-1:0]   o_wb_rd_addr;
  logic                o_wb_reg_write;
  logic                o_misaligned;
  logic [NB-1:0]       o_debug_data;

  modport master (
    output i_step, i_alu_result, i_write_data, i_mem_read, i_mem_write,
           i_reg_write, i_mem_to_reg, i_word_size, i_branch, i_cero,
           i_branch_addr, i_rd_addr, i_debug_addr,
    input  o_pc_src, o_branch_addr, o_wb_data, o_wb_rd_addr,
           o_wb_reg_write, o_misaligned, o_debug_data
  );

  modport slave (
    input  i_step, i_alu_result, i_write_data, i_mem_read, i_mem_write,
           i_reg_write, i_mem_to_reg, i_word_size, i_branch, i_cero,
           i_branch_addr, i_rd_addr, i_debug_addr,
    output o_pc_src, o_branch_addr, o_wb_data, o_wb_rd_addr,
           o_wb_reg_write, o_misaligned, o_debug_data
  );

endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   MEM stage of the 5-stage MIPS pipeline. Holds the data memory, performs
//   LB/LH/LW/LBU/LHU/SB/SH/SW accesses, resolves the branch decision and
//   latches the MEM/WB boundary. State advances only when i_step is high so the
//   debug unit can single-step the core.
// Ports
//   i_clk     system clock, rising edge
//   i_reset   asynchronous, active-low reset
//   bus       mem_stage_if.slave (see mem_stage_if for signal list)
// Configuration
//   MEM_DEBUG_PORT_EN : when defined, o_debug_data = mem[i_debug_addr]
//                       (combinational second read port); otherwise tied to 0.
// Notes
//   Memory is little-endian, word-indexed by alu_result[NB_ADDR+1:2]; upper
//   address bits are ignored so indices wrap modulo the depth. The memory
//   array is never cleared by reset.
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned NB      = 32,
  parameter int unsigned NB_ADDR = 8,
  parameter int unsigned NB_REG  = 5
) (
  input  logic         i_clk,
  input  logic         i_reset,
  mem_stage_if.slave   bus
);

  localparam int unsigned DEPTH    = 1 << NB_ADDR;
  localparam int unsigned NB_LANES = NB / 8;

  // Storage
  logic [NB-1:0] mem_q [DEPTH];

  // Address decode
  logic [NB_ADDR-1:0]  word_idx;
  logic [1:0]          byte_off;

  // Access qualification
  logic                is_byte;
  logic                is_half;
  logic                is_word;
  logic                zext;
  logic                mem_access_c;
  logic                misaligned_c;
  logic                store_en_c;

  // Load path
  logic [NB-1:0]       rd_word;
  logic [NB-1:0]       rd_shifted;
  logic [NB-1:0]       load_c;

  // Store path
  logic [NB_LANES-1:0] wr_mask;
  logic [NB-1:0]       wr_data;

  // MEM/WB boundary registers
  logic [NB-1:0]       wb_data_q,  wb_data_d;
  logic [NB_REG-1:0]   wb_rd_q,    wb_rd_d;
  logic                wb_regw_q,  wb_regw_d;
  logic                mis_q,      mis_d;

  // Address split: word index and byte offset
  assign word_idx = bus.i_alu_result[NB_ADDR+1:2];
  assign byte_off = bus.i_alu_result[1:0];

  // Size decode; any encoding other than byte/half is treated as word
  assign is_byte = (bus.i_word_size[1:0] == 2'b00);
  assign is_half = (bus.i_word_size[1:0] == 2'b01);
  assign is_word = !is_byte && !is_half;
  assign zext    = bus.i_word_size[2];

  // Only real memory instructions can be flagged misaligned
  assign mem_access_c = bus.i_mem_read | bus.i_mem_write;
  assign misaligned_c = mem_access_c &&
                        ((is_half && byte_off[0]) ||
                         (is_word && (byte_off != 2'b00)));

  assign store_en_c = bus.i_step & bus.i_mem_write & ~misaligned_c;

  // Branch decision goes straight to IF, not gated by i_step
  assign bus.o_pc_src      = bus.i_branch & bus.i_cero;
  assign bus.o_branch_addr = bus.i_branch_addr;

  // Load extraction: shift the addressed lane(s) down, then extend.
  // A read+write access sees this pre-store value since the array updates on the edge.
  assign rd_word    = mem_q[word_idx];
  assign rd_shifted = rd_word >> {byte_off, 3'b000};

  always_comb begin
    load_c = '0;
    if (!misaligned_c) begin
      if (is_byte) begin
        load_c = {{(NB-8){rd_shifted[7] & ~zext}}, rd_shifted[7:0]};
      end else if (is_half) begin
        load_c = {{(NB-16){rd_shifted[15] & ~zext}}, rd_shifted[15:0]};
      end else begin
        load_c = rd_word;
      end
    end
  end

  // Store lane mask and lane-replicated data
  always_comb begin
    wr_mask = '1;
    wr_data = bus.i_write_data;
    if (is_byte) begin
      wr_mask = NB_LANES'(1) << byte_off;
      wr_data = {NB_LANES{bus.i_write_data[7:0]}};
    end else if (is_half) begin
      wr_mask = NB_LANES'(3) << byte_off;
      wr_data = {(NB_LANES/2){bus.i_write_data[15:0]}};
    end
  end

  // Memory write port; reset only blocks an in-flight store, contents are kept
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      // array intentionally left untouched
    end else if (store_en_c) begin
      for (int unsigned l = 0; l < NB_LANES; l++) begin
        if (wr_mask[l]) begin
          mem_q[word_idx][l*8 +: 8] <= wr_data[l*8 +: 8];
        end
      end
    end
  end

  // MEM/WB next state: hold unless stepped
  always_comb begin
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_regw_d = wb_regw_q;
    mis_d     = mis_q;
    if (bus.i_step) begin
      wb_data_d = bus.i_mem_to_reg ? load_c : bus.i_alu_result;
      wb_rd_d   = bus.i_rd_addr;
      wb_regw_d = bus.i_reg_write & ~misaligned_c;
      mis_d     = misaligned_c;
    end
  end

  // MEM/WB state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_regw_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_regw_q <= wb_regw_d;
      mis_q     <= mis_d;
    end
  end

  assign bus.o_wb_data      = wb_data_q;
  assign bus.o_wb_rd_addr   = wb_rd_q;
  assign bus.o_wb_reg_write = wb_regw_q;
  assign bus.o_misaligned   = mis_q;

`ifdef MEM_DEBUG_PORT_EN
  // Debug read port: shows pre-edge contents for a same-word store this cycle
  assign bus.o_debug_data = mem_q[bus.i_debug_addr];

  logic unused_c;
  assign unused_c = ^{bus.i_alu_result[NB-1:NB_ADDR+2]};
`else
  assign bus.o_debug_data = '0;

  logic unused_c;
  assign unused_c = ^{bus.i_alu_result[NB-1:NB_ADDR+2], bus.i_debug_addr};
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int unsigned NB      = 32;
  localparam int unsigned NB_ADDR = 8;
  localparam int unsigned NB_REG  = 5;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_stage_if #(.NB(NB), .NB_ADDR(NB_ADDR), .NB_REG(NB_REG)) bus ();

  mem_stage #(.NB(NB), .NB_ADDR(NB_ADDR), .NB_REG(NB_REG)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic        regw;
    logic        m2r;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd_addr;
    logic [31:0] exp_data;
    logic        exp_regw;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [4:0]  rd_addr;
    logic        regw;
    logic        mis;
  } exp_t;

  int    checks = 0;
  int    errors = 0;
  exp_t  sb_q[$];
  vec_t  vecs[$];
  exp_t  last_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rd, input logic wr,
                              input logic regw, input logic m2r, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_data, input logic exp_regw,
                              input logic exp_mis);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.regw = regw; v.m2r = m2r;
    v.size = size; v.addr = addr; v.wdata = wdata; v.rd_addr = '0;
    v.exp_data = exp_data; v.exp_regw = exp_regw; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.i_step = 1'b0; bus.i_alu_result = '0; bus.i_write_data = '0;
    bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0; bus.i_reg_write = 1'b0;
    bus.i_mem_to_reg = 1'b0; bus.i_word_size = 3'b010; bus.i_branch = 1'b0;
    bus.i_cero = 1'b0; bus.i_branch_addr = '0; bus.i_rd_addr = '0;
    bus.i_debug_addr = '0;
  endtask

  // Pop the oldest expectation and compare against registered WB outputs
  task automatic check_wb();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected >=1");
      return;
    end
    checks--;
    e = sb_q.pop_front();
    chk({e.name, ".data"},    bus.o_wb_data, e.data);
    chk({e.name, ".rd"},      32'(bus.o_wb_rd_addr), 32'(e.rd_addr));
    chk({e.name, ".regw"},    32'(bus.o_wb_reg_write), 32'(e.regw));
    chk({e.name, ".mis"},     32'(bus.o_misaligned), 32'(e.mis));
    last_exp = e;
  endtask

  // Drive one stepped instruction, push its expectation, compare after the edge
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    bus.i_step = 1'b1; bus.i_mem_read = v.rd; bus.i_mem_write = v.wr;
    bus.i_reg_write = v.regw; bus.i_mem_to_reg = v.m2r; bus.i_word_size = v.size;
    bus.i_alu_result = v.addr; bus.i_write_data = v.wdata; bus.i_rd_addr = v.rd_addr;
    e.name = v.name; e.data = v.exp_data; e.rd_addr = v.rd_addr;
    e.regw = v.exp_regw; e.mis = v.exp_mis;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_wb();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rd wr regw m2r size addr wdata -> data regw mis
    vecs.push_back(mk("sw_10",     0,1,0,0,3'b010,32'h10,       32'hDEADBEEF,32'h00000010,0,0));
    vecs.push_back(mk("lw_10",     1,0,1,1,3'b010,32'h10,       32'h0,       32'hDEADBEEF,1,0));
    vecs.push_back(mk("lb_13",     1,0,1,1,3'b000,32'h13,       32'h0,       32'hFFFFFFDE,1,0));
    vecs.push_back(mk("lbu_13",    1,0,1,1,3'b100,32'h13,       32'h0,       32'h000000DE,1,0));
    vecs.push_back(mk("lhu_10",    1,0,1,1,3'b101,32'h10,       32'h0,       32'h0000BEEF,1,0));
    vecs.push_back(mk("lh_12",     1,0,1,1,3'b001,32'h12,       32'h0,       32'hFFFFDEAD,1,0));
    vecs.push_back(mk("sb_11",     0,1,0,0,3'b000,32'h11,       32'hAABBCC55,32'h00000011,0,0));
    vecs.push_back(mk("lw_after_sb",1,0,1,1,3'b010,32'h10,      32'h0,       32'hDEAD55EF,1,0));
    vecs.push_back(mk("sh_12",     0,1,0,0,3'b001,32'h12,       32'hFFFF1234,32'h00000012,0,0));
    vecs.push_back(mk("lw_after_sh",1,0,1,1,3'b010,32'h10,      32'h0,       32'h123455EF,1,0));
    vecs.push_back(mk("lw_mis_12", 1,0,1,1,3'b010,32'h12,       32'h0,       32'h00000000,0,1));
    vecs.push_back(mk("sw_mis_11", 0,1,0,0,3'b010,32'h11,       32'hFFFFFFFF,32'h00000011,0,1));
    vecs.push_back(mk("lh_mis_11", 1,0,1,1,3'b001,32'h11,       32'h0,       32'h00000000,0,1));
    vecs.push_back(mk("lw_unchg",  1,0,1,1,3'b010,32'h10,       32'h0,       32'h123455EF,1,0));
    vecs.push_back(mk("alu_op",    0,0,1,0,3'b010,32'h12345673, 32'h0,       32'h12345673,1,0));
    vecs.push_back(mk("sw_wrap",   0,1,0,0,3'b010,32'hBFC,      32'hCAFEF00D,32'h00000BFC,0,0));
    vecs.push_back(mk("lw_wrap",   1,0,1,1,3'b010,32'h3FC,      32'h0,       32'hCAFEF00D,1,0));
    vecs.push_back(mk("sw_20",     0,1,0,0,3'b010,32'h20,       32'h0BADF00D,32'h00000020,0,0));
    vecs.push_back(mk("rw_20",     1,1,1,1,3'b010,32'h20,       32'h11112222,32'h0BADF00D,1,0));
    vecs.push_back(mk("lw_20",     1,0,1,1,3'b010,32'h20,       32'h0,       32'h11112222,1,0));
    vecs.push_back(mk("lb_10",     1,0,1,1,3'b000,32'h10,       32'h0,       32'hFFFFFFEF,1,0));
    vecs.push_back(mk("lbu_11",    1,0,1,1,3'b100,32'h11,       32'h0,       32'h00000055,1,0));
    vecs.push_back(mk("lhu_12",    1,0,1,1,3'b101,32'h12,       32'h0,       32'h00001234,1,0));
    vecs.push_back(mk("lh_10",     1,0,1,1,3'b001,32'h10,       32'h0,       32'h000055EF,1,0));

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst.data", bus.o_wb_data, 32'h0);
    chk("rst.rd",   32'(bus.o_wb_rd_addr), 32'h0);
    chk("rst.regw", 32'(bus.o_wb_reg_write), 32'h0);
    chk("rst.mis",  32'(bus.o_misaligned), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      v.rd_addr = 5'(i + 1);
      apply(v);
    end

    // Not stepped: store must not land, WB outputs hold
    @(negedge clk);
    bus.i_step = 1'b0; bus.i_mem_write = 1'b1; bus.i_mem_read = 1'b0;
    bus.i_word_size = 3'b010; bus.i_alu_result = 32'h10; bus.i_write_data = 32'h0;
    bus.i_reg_write = 1'b1; bus.i_mem_to_reg = 1'b0; bus.i_rd_addr = 5'd31;
    @(posedge clk);
    #1;
    chk("hold.data", bus.o_wb_data, last_exp.data);
    chk("hold.rd",   32'(bus.o_wb_rd_addr), 32'(last_exp.rd_addr));
    chk("hold.regw", 32'(bus.o_wb_reg_write), 32'(last_exp.regw));
    apply(mk("lw_after_hold",1,0,1,1,3'b010,32'h10,32'h0,32'h123455EF,1,0));

    // Branch decision is combinational and independent of i_step
    @(negedge clk);
    bus.i_step = 1'b0; bus.i_mem_write = 1'b0; bus.i_mem_read = 1'b0;
    bus.i_branch = 1'b1; bus.i_cero = 1'b1; bus.i_branch_addr = 32'h00400080;
    #1;
    chk("pc_src.taken", 32'(bus.o_pc_src), 32'h1);
    chk("branch_addr",  bus.o_branch_addr, 32'h00400080);
    bus.i_cero = 1'b0;
    #1;
    chk("pc_src.nz", 32'(bus.o_pc_src), 32'h0);
    bus.i_branch = 1'b0; bus.i_cero = 1'b1;
    #1;
    chk("pc_src.nobr", 32'(bus.o_pc_src), 32'h0);
    bus.i_cero = 1'b0;

    // Reset mid-sequence: outputs clear asynchronously, in-flight store dropped
    apply(mk("lw_pre_rst",1,0,1,1,3'b010,32'h20,32'h0,32'h11112222,1,0));
    @(negedge clk);
    bus.i_step = 1'b1; bus.i_mem_write = 1'b1; bus.i_mem_read = 1'b0;
    bus.i_word_size = 3'b010; bus.i_alu_result = 32'h10; bus.i_write_data = 32'hFFFFFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.data", bus.o_wb_data, 32'h0);
    chk("arst.regw", 32'(bus.o_wb_reg_write), 32'h0);
    chk("arst.rd",   32'(bus.o_wb_rd_addr), 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold.data", bus.o_wb_data, 32'h0);
    @(negedge clk);
    bus.i_mem_write = 1'b0; bus.i_step = 1'b0;
    rst_n = 1'b1;
    bus.i_debug_addr = 8'd4;
    #1;
`ifdef MEM_DEBUG_PORT_EN
    chk("debug.addr4", bus.o_debug_data, 32'h123455EF);
`else
    chk("debug.tied", bus.o_debug_data, 32'h0);
`endif
    apply(mk("lw_post_rst",1,0,1,1,3'b010,32'h10,32'h0,32'h123455EF,1,0));
    apply(mk("lw20_post_rst",1,0,1,1,3'b010,32'h20,32'h0,32'h11112222,1,0));

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
